// File: rtl/ret_stack_param_if.sv
// rtl/ret_stack_param_if.sv - Push/pop request and stack status bundle for ret_stack_param.
interface ret_stack_param_if #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] DI;
   logic             ENA;
   logic             RTS;
   logic             CLR_ERR;
   logic [WIDTH-1:0] DO;
   logic [CW-1:0]    CNT;
   logic             EMPTY;
   logic             FULL;
   logic             OVF;
   logic             UNF;

   modport master (
      output DI, ENA, RTS, CLR_ERR,
      input  DO, CNT, EMPTY, FULL, OVF, UNF
   );

   modport slave (
      input  DI, ENA, RTS, CLR_ERR,
      output DO, CNT, EMPTY, FULL, OVF, UNF
   );
endinterface

// File: rtl/ret_stack_param.sv
// rtl/ret_stack_param.sv - Parametrised return-address LIFO with registered top, count and sticky error flags.
// RET_STACK_CIRC_EN: push on a full stack overwrites the oldest entry instead of being discarded.
module ret_stack_param #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic              CLK2,
   input  logic              RST_N,
   ret_stack_param_if.slave  bus
);
   localparam int             CW       = $clog2(DEPTH + 1);
   localparam int             IW       = $clog2(DEPTH);
   localparam logic [IW-1:0]  LAST_IDX = IW'(DEPTH - 1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [IW-1:0]    r_sp;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_do;
   logic             r_ovf;
   logic             r_unf;

   logic [IW-1:0]    w_top;
   logic [IW-1:0]    w_below;
   logic             w_empty;
   logic             w_full;
   logic [IW-1:0]    w_sp_n;
   logic [CW-1:0]    w_cnt_n;
   logic [WIDTH-1:0] w_do_n;
   logic             w_we;
   logic [IW-1:0]    w_waddr;
   logic             w_ovf_set;
   logic             w_unf_set;

   // Explicit wrap compare so non-power-of-two depths stay in range.
   function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] a);
      return (a == LAST_IDX) ? '0 : a + IW'(1);
   endfunction

   function automatic logic [IW-1:0] f_dec(input logic [IW-1:0] a);
      return (a == '0) ? LAST_IDX : a - IW'(1);
   endfunction

   assign w_top   = f_dec(r_sp);
   assign w_below = f_dec(w_top);
   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == FULL_CNT);

   always_comb begin
      w_sp_n    = r_sp;
      w_cnt_n   = r_cnt;
      w_do_n    = r_do;
      w_we      = 1'b0;
      w_waddr   = r_sp;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
      case ({bus.ENA, bus.RTS})
         2'b10: begin
            if (!w_full) begin
               w_we    = 1'b1;
               w_sp_n  = f_inc(r_sp);
               w_cnt_n = r_cnt + CW'(1);
               w_do_n  = bus.DI;
            end else begin
               w_ovf_set = 1'b1;
`ifdef RET_STACK_CIRC_EN
               // When full, SP sits on the oldest entry, so writing there drops the bottom.
               w_we   = 1'b1;
               w_sp_n = f_inc(r_sp);
               w_do_n = bus.DI;
`endif
            end
         end
         2'b01: begin
            if (!w_empty) begin
               w_sp_n  = w_top;
               w_cnt_n = r_cnt - CW'(1);
               w_do_n  = (r_cnt == CW'(1)) ? '0 : r_mem[w_below];
            end else begin
               w_unf_set = 1'b1;
            end
         end
         2'b11: begin
            w_we   = 1'b1;
            w_do_n = bus.DI;
            if (!w_empty) begin
               w_waddr = w_top;
            end else begin
               w_sp_n    = f_inc(r_sp);
               w_cnt_n   = CW'(1);
               w_unf_set = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK2 or negedge RST_N) begin
      if (!RST_N) begin
         r_sp  <= '0;
         r_cnt <= '0;
         r_do  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_sp  <= w_sp_n;
         r_cnt <= w_cnt_n;
         r_do  <= w_do_n;
         r_ovf <= w_ovf_set | (r_ovf & ~bus.CLR_ERR);
         r_unf <= w_unf_set | (r_unf & ~bus.CLR_ERR);
      end
   end

   always_ff @(posedge CLK2) begin
      if (RST_N && w_we) begin
         r_mem[w_waddr] <= bus.DI;
      end
   end

   assign bus.DO    = r_do;
   assign bus.CNT   = r_cnt;
   assign bus.EMPTY = w_empty;
   assign bus.FULL  = w_full;
   assign bus.OVF   = r_ovf;
   assign bus.UNF   = r_unf;
endmodule

// File: tb/tb_ret_stack_param.sv
// tb/tb_ret_stack_param.sv - Directed bench for ret_stack_param at DEPTH=4 and DEPTH=3.
module tb_ret_stack_param;
   logic CLK2;
   logic RST_N;
   int   n_checks;
   int   n_fail;

   ret_stack_param_if #(.WIDTH(20), .DEPTH(4)) b4 ();
   ret_stack_param_if #(.WIDTH(20), .DEPTH(3)) b3 ();

   ret_stack_param #(.WIDTH(20), .DEPTH(4)) u_dut4 (.CLK2(CLK2), .RST_N(RST_N), .bus(b4));
   ret_stack_param #(.WIDTH(20), .DEPTH(3)) u_dut3 (.CLK2(CLK2), .RST_N(RST_N), .bus(b3));

   initial CLK2 = 1'b0;
   always #5 CLK2 = ~CLK2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK2);
      #1;
   endtask

   task automatic op4(input logic ena, input logic rts, input logic clr, input logic [19:0] di);
      b4.ENA = ena; b4.RTS = rts; b4.CLR_ERR = clr; b4.DI = di;
      tick();
      b4.ENA = 1'b0; b4.RTS = 1'b0; b4.CLR_ERR = 1'b0;
   endtask

   task automatic op3(input logic ena, input logic rts, input logic [19:0] di);
      b3.ENA = ena; b3.RTS = rts; b3.CLR_ERR = 1'b0; b3.DI = di;
      tick();
      b3.ENA = 1'b0; b3.RTS = 1'b0;
   endtask

   logic [19:0] q[$];
   int          n5;

   task automatic m3_check();
      logic [19:0] exp_do;
      exp_do = (q.size() > 0) ? q[q.size()-1] : 20'h0;
      check($sformatf("t5_do_%0d", n5), 32'(b3.DO), 32'(exp_do));
      check($sformatf("t5_cnt_%0d", n5), 32'(b3.CNT), 32'(q.size()));
      n5++;
   endtask

   task automatic m3_push(input logic [19:0] d);
      op3(1'b1, 1'b0, d);
      if (q.size() < 3) q.push_back(d);
`ifdef RET_STACK_CIRC_EN
      else begin
         void'(q.pop_front());
         q.push_back(d);
      end
`endif
      m3_check();
   endtask

   task automatic m3_pop();
      op3(1'b0, 1'b1, 20'h0);
      if (q.size() > 0) void'(q.pop_back());
      m3_check();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n5       = 0;
      b4.ENA = 1'b0; b4.RTS = 1'b0; b4.CLR_ERR = 1'b0; b4.DI = '0;
      b3.ENA = 1'b0; b3.RTS = 1'b0; b3.CLR_ERR = 1'b0; b3.DI = '0;
      RST_N = 1'b0;
      repeat (2) tick();
      check("rst_do",    32'(b4.DO), 32'h0);
      check("rst_cnt",   32'(b4.CNT), 32'h0);
      check("rst_empty", 32'(b4.EMPTY), 32'h1);
      check("rst_full",  32'(b4.FULL), 32'h0);
      check("rst_ovf",   32'(b4.OVF), 32'h0);
      check("rst_unf",   32'(b4.UNF), 32'h0);
      RST_N = 1'b1;
      tick();

      // Test 1: three pushes then three pops
      op4(1, 0, 0, 20'h00011);
      op4(1, 0, 0, 20'h00022);
      op4(1, 0, 0, 20'h00033);
      check("t1_do",  32'(b4.DO), 32'h33);
      check("t1_cnt", 32'(b4.CNT), 32'd3);
      op4(0, 1, 0, 20'h0); check("t1_pop1", 32'(b4.DO), 32'h22);
      op4(0, 1, 0, 20'h0); check("t1_pop2", 32'(b4.DO), 32'h11);
      op4(0, 1, 0, 20'h0); check("t1_pop3", 32'(b4.DO), 32'h0);
      check("t1_empty", 32'(b4.EMPTY), 32'h1);

      // Test 2: overflow at DEPTH=4
      for (int i = 1; i <= 5; i++) op4(1, 0, 0, 20'(i));
      check("t2_cnt",  32'(b4.CNT), 32'd4);
      check("t2_full", 32'(b4.FULL), 32'h1);
      check("t2_ovf",  32'(b4.OVF), 32'h1);
`ifdef RET_STACK_CIRC_EN
      check("t2_do", 32'(b4.DO), 32'd5);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_pop_in_%0d", i), 32'(b4.DO), 32'(5 - i));
         op4(0, 1, 0, 20'h0);
      end
`else
      check("t2_do", 32'(b4.DO), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_pop_in_%0d", i), 32'(b4.DO), 32'(4 - i));
         op4(0, 1, 0, 20'h0);
      end
`endif
      check("t2_empty", 32'(b4.EMPTY), 32'h1);
      op4(0, 0, 1, 20'h0);
      check("t2_ovf_clr", 32'(b4.OVF), 32'h0);

      // Test 3: underflow and clear priority
      op4(0, 1, 0, 20'h0);
      check("t3_unf", 32'(b4.UNF), 32'h1);
      check("t3_cnt", 32'(b4.CNT), 32'h0);
      check("t3_do",  32'(b4.DO), 32'h0);
      op4(0, 1, 1, 20'h0);
      check("t3_unf_setwins", 32'(b4.UNF), 32'h1);
      op4(0, 0, 1, 20'h0);
      check("t3_unf_clr", 32'(b4.UNF), 32'h0);

      // Test 4: replace
      op4(1, 0, 0, 20'hAAAAA);
      op4(1, 1, 0, 20'hBBBBB);
      check("t4_do",  32'(b4.DO), 32'hBBBBB);
      check("t4_cnt", 32'(b4.CNT), 32'd1);
      check("t4_unf", 32'(b4.UNF), 32'h0);
      op4(0, 1, 0, 20'h0);
      check("t4_empty", 32'(b4.EMPTY), 32'h1);
      op4(1, 1, 0, 20'hCCCCC);
      check("t4e_cnt", 32'(b4.CNT), 32'd1);
      check("t4e_unf", 32'(b4.UNF), 32'h1);
      check("t4e_do",  32'(b4.DO), 32'hCCCCC);

      // Test 5: DEPTH=3 bursts with wrap against a queue model
      for (int b = 0; b < 10; b++) begin
         m3_push(20'(32'h100 + 2 * b));
         m3_push(20'(32'h101 + 2 * b));
         m3_pop();
      end
      check("t5_ovf", 32'(b3.OVF), 32'h1);
      check("t5_unf", 32'(b3.UNF), 32'h0);

      // Test 6: asynchronous reset between edges
      op4(1, 0, 0, 20'h00077);
      op4(1, 0, 0, 20'h00088);
      b4.ENA = 1'b1; b4.DI = 20'h00099;
      @(posedge CLK2);
      #3;
      RST_N = 1'b0;
      #1;
      check("t6_do",    32'(b4.DO), 32'h0);
      check("t6_cnt",   32'(b4.CNT), 32'h0);
      check("t6_empty", 32'(b4.EMPTY), 32'h1);
      check("t6_unf",   32'(b4.UNF), 32'h0);
      check("t6_cnt3",  32'(b3.CNT), 32'h0);
      check("t6_ovf3",  32'(b3.OVF), 32'h0);
      b4.ENA = 1'b0;
      tick();
      RST_N = 1'b1;
      tick();
      check("t6_post_cnt", 32'(b4.CNT), 32'h0);
      check("t6_post_do",  32'(b4.DO), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
